// File: rtl/execute_alu_unit.sv
// execute_alu_unit: execute-stage ALU registering one result per op into EX/MEM under valid/ready.
// Defining EXECUTE_MUL_EN adds an iterative XLEN-step shift-add multiply that stalls decode while busy.
`ifndef ALU_ADD
`define ALU_ADD 3'b000
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'b001
`endif
`ifndef ALU_AND
`define ALU_AND 3'b010
`endif
`ifndef ALU_OR
`define ALU_OR 3'b011
`endif
`ifndef ALU_XOR
`define ALU_XOR 3'b100
`endif
module execute_alu_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_VALID,
  output logic                  EX_READY,
  input  logic [2:0]            ALU_CONTROL,
  input  logic                  IS_MUL,
  input  logic [XLEN-1:0]       SRC_A,
  input  logic [XLEN-1:0]       SRC_B,
  input  logic [REG_ADDR_W-1:0] RD_IN,
  input  logic                  REG_WRITE_IN,
  input  logic                  FLUSH,
  input  logic                  MEM_READY,
  output logic                  EX_VALID,
  output logic [XLEN-1:0]       ALU_RESULT,
  output logic                  ZERO,
  output logic [REG_ADDR_W-1:0] RD_OUT,
  output logic                  REG_WRITE_OUT,
  output logic                  BUSY
);
  logic                  ex_valid, ex_valid_d, zero, zero_d, rw, rw_d, accept;
  logic [XLEN-1:0]       result, result_d, alu_out;
  logic [REG_ADDR_W-1:0] rd, rd_d;
  assign alu_out = ALU_CONTROL == `ALU_SUB ? SRC_A - SRC_B :
                   ALU_CONTROL == `ALU_AND ? SRC_A & SRC_B :
                   ALU_CONTROL == `ALU_OR  ? SRC_A | SRC_B :
                   ALU_CONTROL == `ALU_XOR ? SRC_A ^ SRC_B : SRC_A + SRC_B;
  assign accept        = ID_VALID && EX_READY && !FLUSH;
  assign EX_VALID      = ex_valid;
  assign ALU_RESULT    = result;
  assign ZERO          = zero;
  assign RD_OUT        = rd;
  assign REG_WRITE_OUT = rw;
`ifdef EXECUTE_MUL_EN
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  typedef enum logic {IDLE, MUL_RUN} state_t;
  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [2*XLEN-1:0]     prod, prod_d, prod_step;
  logic [XLEN-1:0]       mcand, mcand_d;
  logic [XLEN:0]         hi_sum;
  logic [REG_ADDR_W-1:0] mul_rd, mul_rd_d;
  logic                  mul_rw, mul_rw_d;
  assign EX_READY  = state == IDLE && (!ex_valid || MEM_READY);
  assign BUSY      = state == MUL_RUN;
  // Multiplier sits in the low half and shifts out as partial sums enter the high half.
  assign hi_sum    = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_step = {hi_sum, prod[XLEN-1:1]};
`else
  logic unused_is_mul;
  assign unused_is_mul = IS_MUL;
  assign EX_READY      = !ex_valid || MEM_READY;
  assign BUSY          = 1'b0;
`endif
  always_comb begin
    ex_valid_d = ex_valid && !MEM_READY;
    result_d   = result;
    zero_d     = zero;
    rd_d       = rd;
    rw_d       = rw;
`ifdef EXECUTE_MUL_EN
    state_d    = state;
    cnt_d      = cnt;
    prod_d     = prod;
    mcand_d    = mcand;
    mul_rd_d   = mul_rd;
    mul_rw_d   = mul_rw;
`endif
    if (FLUSH) begin
      ex_valid_d = 1'b0;
`ifdef EXECUTE_MUL_EN
      state_d    = IDLE;
      cnt_d      = '0;
`endif
    end
`ifdef EXECUTE_MUL_EN
    else if (state == MUL_RUN) begin
      if (cnt != LAST) begin
        prod_d = prod_step;
        cnt_d  = cnt + 1'b1;
      end else if (!ex_valid || MEM_READY) begin
        ex_valid_d = 1'b1;
        result_d   = prod_step[XLEN-1:0];
        zero_d     = prod_step[XLEN-1:0] == '0;
        rd_d       = mul_rd;
        rw_d       = mul_rw;
        state_d    = IDLE;
        cnt_d      = '0;
      end
    end else if (accept && IS_MUL) begin
      state_d  = MUL_RUN;
      cnt_d    = '0;
      prod_d   = {{XLEN{1'b0}}, SRC_B};
      mcand_d  = SRC_A;
      mul_rd_d = RD_IN;
      mul_rw_d = REG_WRITE_IN;
    end
`endif
    else if (accept) begin
      ex_valid_d = 1'b1;
      result_d   = alu_out;
      zero_d     = alu_out == '0;
      rd_d       = RD_IN;
      rw_d       = REG_WRITE_IN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      rd       <= '0;
      rw       <= 1'b0;
    end else begin
      ex_valid <= ex_valid_d;
      result   <= result_d;
      zero     <= zero_d;
      rd       <= rd_d;
      rw       <= rw_d;
    end
  end
`ifdef EXECUTE_MUL_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mul_rd <= '0;
      mul_rw <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      prod   <= prod_d;
      mcand  <= mcand_d;
      mul_rd <= mul_rd_d;
      mul_rw <= mul_rw_d;
    end
  end
`endif
endmodule

// File: tb/tb_execute_alu_unit.sv
// tb_execute_alu_unit: directed and randomized checks of execute_alu_unit against a behavioural model.
module tb_execute_alu_unit;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3, OP_XOR = 3'd4;
  logic clk = 0, rst_n = 0, id_valid = 0, is_mul = 0, reg_write_in = 0, flush = 0, mem_ready = 1;
  logic [2:0] alu_control = 0;
  logic [31:0] src_a = 0, src_b = 0;
  logic [4:0] rd_in = 0;
  logic ex_ready, ex_valid, zero, reg_write_out, busy;
  logic [31:0] alu_result;
  logic [4:0] rd_out;
  int errors = 0, checks = 0;
  execute_alu_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ID_VALID(id_valid), .EX_READY(ex_ready),
    .ALU_CONTROL(alu_control), .IS_MUL(is_mul), .SRC_A(src_a), .SRC_B(src_b),
    .RD_IN(rd_in), .REG_WRITE_IN(reg_write_in), .FLUSH(flush), .MEM_READY(mem_ready),
    .EX_VALID(ex_valid), .ALU_RESULT(alu_result), .ZERO(zero), .RD_OUT(rd_out),
    .REG_WRITE_OUT(reg_write_out), .BUSY(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Behavioural model: pipeline slot plus a pending multiply that completes after 32 cycles.
  logic m_valid = 0, m_zero = 0, m_rw = 0, m_busy = 0, m_prw = 0, m_rdy = 0, started = 0;
  logic [31:0] m_res = 0, m_prod = 0;
  logic [4:0] m_rd = 0, m_prd = 0;
  int m_rem = 0;
  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return a + b;
    endcase
  endfunction
  always @(posedge clk) begin
    m_rdy = !m_busy && (!m_valid || mem_ready);
    if (!rst_n) begin
      m_valid = 0; m_res = 0; m_zero = 0; m_rd = 0; m_rw = 0; m_busy = 0; m_rem = 0;
      started = 1;
    end else if (flush) begin
      m_valid = 0;
      m_busy  = 0;
    end else if (m_busy) begin
      if (m_rem > 1) begin
        m_rem--;
        if (mem_ready) m_valid = 0;
      end else if (!m_valid || mem_ready) begin
        m_valid = 1; m_res = m_prod; m_zero = (m_prod == 0); m_rd = m_prd; m_rw = m_prw; m_busy = 0;
      end
    end else begin
      if (mem_ready) m_valid = 0;
      if (id_valid && m_rdy) begin
`ifdef EXECUTE_MUL_EN
        if (is_mul) begin
          m_busy = 1; m_rem = 32; m_prod = 32'({32'd0, src_a} * {32'd0, src_b});
          m_prd = rd_in; m_prw = reg_write_in;
        end else
`endif
        begin
          m_valid = 1; m_res = alu(alu_control, src_a, src_b); m_zero = (m_res == 0);
          m_rd = rd_in; m_rw = reg_write_in;
        end
      end
    end
  end
  always @(negedge clk) if (started) begin
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("ex_ready", 32'(ex_ready), 32'(!m_busy && (!m_valid || mem_ready)));
    chk("busy", 32'(busy), 32'(m_busy));
    if (m_valid) begin
      chk("alu_result", alu_result, m_res);
      chk("zero", 32'(zero), 32'(m_zero));
      chk("rd_out", 32'(rd_out), 32'(m_rd));
      chk("reg_write_out", 32'(reg_write_out), 32'(m_rw));
    end
  end
  task automatic step(input logic v, input logic [2:0] op, input logic m, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd, input logic rw, input logic fl,
                      input logic mr, input logic rs);
    id_valid = v; alu_control = op; is_mul = m; src_a = a; src_b = b; rd_in = rd;
    reg_write_in = rw; flush = fl; mem_ready = mr; rst_n = rs;
    @(posedge clk); #1;
  endtask
  task automatic idle(input logic mr);
    step(0, OP_ADD, 0, 0, 0, 0, 0, 0, mr, 1);
  endtask
  logic [31:0] ra, rb;
  initial begin
    step(0, OP_ADD, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, OP_ADD, 0, 0, 0, 0, 0, 0, 1, 0);
    rst_n = 1; #1;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_result", alu_result, 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_rd", 32'(rd_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ex_ready", 32'(ex_ready), 1);
    step(1, OP_ADD, 0, 32'hFFFF_FFFF, 32'd1, 5'd5, 1, 0, 1, 1);
    chk("add_valid", 32'(ex_valid), 1);
    chk("add_wrap", alu_result, 0);
    chk("add_zero", 32'(zero), 1);
    chk("add_rd", 32'(rd_out), 5);
    step(1, OP_SUB, 0, 32'd7, 32'd9, 5'd3, 1, 0, 1, 1);
    chk("sub_result", alu_result, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      step(1, OP_AND, 0, 32'h1, 32'h1, 5'd8, 0, 0, 0, 1);
      chk("hold_result", alu_result, 32'hFFFF_FFFE);
      chk("hold_ready", 32'(ex_ready), 0);
      chk("hold_rd", 32'(rd_out), 3);
    end
    step(1, OP_XOR, 0, 32'hF0, 32'hFF, 5'd4, 1, 0, 1, 1);
    chk("xor_valid", 32'(ex_valid), 1);
    chk("xor_result", alu_result, 32'h0F);
    step(1, 3'd7, 0, 32'd10, 32'd20, 5'd6, 1, 0, 1, 1);
    chk("code7_as_add", alu_result, 32'd30);
    idle(1);
    chk("consume_drop", 32'(ex_valid), 0);
`ifdef EXECUTE_MUL_EN
    step(1, OP_ADD, 1, 32'd1234, 32'd5678, 5'd9, 1, 0, 1, 1);
    chk("mul_busy", 32'(busy), 1);
    for (int i = 1; i < 32; i++) begin
      idle(1);
      chk("mul_busy", 32'(busy), 1);
      chk("mul_not_ready", 32'(ex_ready), 0);
    end
    idle(1);
    chk("mul_valid", 32'(ex_valid), 1);
    chk("mul_result", alu_result, 32'd7006652);
    chk("mul_rd", 32'(rd_out), 9);
    chk("mul_done", 32'(busy), 0);
    idle(1);
    step(1, OP_ADD, 1, 32'd33, 32'd44, 5'd2, 1, 0, 1, 1);
    repeat (9) idle(1);
    step(0, OP_ADD, 0, 0, 0, 0, 0, 1, 1, 1);
    chk("flush_busy", 32'(busy), 0);
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_ready", 32'(ex_ready), 1);
    for (int i = 0; i < 40; i++) begin
      idle(1);
      chk("flush_no_result", 32'(ex_valid), 0);
    end
    step(1, OP_ADD, 1, 32'd3, 32'd4, 5'd7, 1, 0, 1, 1);
    repeat (5) idle(1);
`else
    step(1, OP_ADD, 1, 32'd3, 32'd4, 5'd7, 1, 0, 1, 1);
    chk("mul_ignored", alu_result, 32'd7);
    idle(0);
`endif
    step(1, OP_ADD, 0, 32'd5, 32'd6, 5'd2, 1, 0, 1, 0);
    chk("rst2_valid", 32'(ex_valid), 0);
    chk("rst2_result", alu_result, 0);
    chk("rst2_rd", 32'(rd_out), 0);
    chk("rst2_rw", 32'(reg_write_out), 0);
    chk("rst2_busy", 32'(busy), 0);
    step(1, OP_ADD, 0, 32'd5, 32'd6, 5'd2, 1, 0, 1, 0);
    chk("rst2_no_accept", 32'(ex_valid), 0);
    idle(1);
    for (int i = 0; i < 3000; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      step($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 7) == 0, ra, rb,
           5'($urandom), 1'($urandom), $urandom_range(0, 40) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 400) != 0);
    end
    idle(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
